// File: rtl/cmp_window_stats.sv
// cmp_window_stats: windowed statistics behind an N-bit comparator.
// Counts Lesser/Greater/Equal outcomes and tracks the unsigned maximum of the
// winning operand over WINDOW accepted samples. It then holds a registered
// summary on a valid/ready handshake and clears for the next window.
// Optional build macro CMP_ONEHOT_CHECK_EN: flags non-one-hot comparator
// results on err. When it is undefined, err is tied to 0.
//
// state     | meaning
// ST_ACCUM  | accepting samples, counters show running values
// ST_REPORT | summary held on outputs until out_valid && out_ready
module cmp_window_stats #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Lesser,
  input  logic             Greater,
  input  logic             Equal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [WIDTH-1:0] max_val,
  output logic             err
);

  localparam logic [0:0]       ST_ACCUM  = 1'b0;
  localparam logic [0:0]       ST_REPORT = 1'b1;
  localparam logic [15:0]      IDX_LAST  = 16'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [0:0]       state_q, state_d;
  logic [15:0]      idx_q, idx_d;
  logic [CNT_W-1:0] lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             accept;
  logic             cls_lt, cls_gt, cls_eq;
  logic [WIDTH-1:0] winner;
  logic             err_set;

  assign in_ready  = (state_q == ST_ACCUM) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_REPORT);

  // Equal wins over Lesser, which wins over Greater; no flag means no count.
  assign cls_eq = Equal;
  assign cls_lt = !Equal && Lesser;
  assign cls_gt = !Equal && !Lesser && Greater;
  assign winner = cls_lt ? b : a;

`ifdef CMP_ONEHOT_CHECK_EN
  logic err_q, err_d;
  logic onehot;

  assign onehot  = ({Lesser, Greater, Equal} == 3'b100) ||
                   ({Lesser, Greater, Equal} == 3'b010) ||
                   ({Lesser, Greater, Equal} == 3'b001);
  assign err_set = accept && !onehot;

  // Sticky error for the window, cleared by the report handshake.
  always_comb begin
    err_d = err_q;
    if (out_valid && out_ready) err_d = 1'b0;
    else if (err_set)           err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err_set = 1'b0;
  assign err     = err_set;
`endif

  // Next-state: accumulate in ACCUM, hold and clear on handshake in REPORT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    max_d   = max_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (cls_lt && lt_q != CNT_MAX) lt_d = lt_q + 1'b1;
          if (cls_gt && gt_q != CNT_MAX) gt_d = gt_q + 1'b1;
          if (cls_eq && eq_q != CNT_MAX) eq_d = eq_q + 1'b1;
          if (winner > max_q) max_d = winner;
          idx_d = idx_q + 16'd1;
          if (idx_q == IDX_LAST) state_d = ST_REPORT;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          idx_d   = '0;
          lt_d    = '0;
          gt_d    = '0;
          eq_d    = '0;
          max_d   = '0;
        end
      end
    endcase
  end

  // State, index and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
      lt_q    <= '0;
      gt_q    <= '0;
      eq_q    <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      max_q   <= max_d;
    end
  end

  assign lt_cnt  = lt_q;
  assign gt_cnt  = gt_q;
  assign eq_cnt  = eq_q;
  assign max_val = max_q;

endmodule

// File: tb/tb_cmp_window_stats.sv
// Directed bench for cmp_window_stats: three instances cover WINDOW=4,
// WINDOW=3 with bubbles, and CNT_W=2 saturation.
module tb_cmp_window_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sa, sb;
  logic        sl, sg, se;

  logic        v4, r4, rdy4, ov4, err4;
  logic [15:0] lt4, gt4, eq4;
  logic [31:0] mx4;

  logic        v3, r3, rdy3, ov3, err3;
  logic [15:0] lt3, gt3, eq3;
  logic [31:0] mx3;

  logic        vs, rs, rdys, ovs, errs;
  logic [1:0]  lts, gts, eqs;
  logic [31:0] mxs;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_err;

  always #5 clk = ~clk;

  cmp_window_stats #(.WIDTH(32), .WINDOW(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .a(sa), .b(sb),
    .Lesser(sl), .Greater(sg), .Equal(se), .out_valid(ov4), .out_ready(r4),
    .lt_cnt(lt4), .gt_cnt(gt4), .eq_cnt(eq4), .max_val(mx4), .err(err4));

  cmp_window_stats #(.WIDTH(32), .WINDOW(3), .CNT_W(16)) u_w3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .a(sa), .b(sb),
    .Lesser(sl), .Greater(sg), .Equal(se), .out_valid(ov3), .out_ready(r3),
    .lt_cnt(lt3), .gt_cnt(gt3), .eq_cnt(eq3), .max_val(mx3), .err(err3));

  cmp_window_stats #(.WIDTH(32), .WINDOW(6), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(vs), .in_ready(rdys), .a(sa), .b(sb),
    .Lesser(sl), .Greater(sg), .Equal(se), .out_valid(ovs), .out_ready(rs),
    .lt_cnt(lts), .gt_cnt(gts), .eq_cnt(eqs), .max_val(mxs), .err(errs));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic put(input logic [31:0] va, input logic [31:0] vb,
                     input logic l, input logic g, input logic e);
    sa = va; sb = vb; sl = l; sg = g; se = e;
  endtask

  task automatic chk4(input string tag, input logic [15:0] l, input logic [15:0] g,
                      input logic [15:0] e, input logic [31:0] m);
    chk({tag, "_lt"}, lt4, l);
    chk({tag, "_gt"}, gt4, g);
    chk({tag, "_eq"}, eq4, e);
    chk({tag, "_max"}, mx4, m);
  endtask

  task automatic handshake4();
    r4 = 1'b1;
    tick();
    r4 = 1'b0;
  endtask

  initial begin
`ifdef CMP_ONEHOT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1;
    v4 = 0; r4 = 0; v3 = 0; r3 = 0; vs = 0; rs = 0;
    put(0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_ov", ov4, 0);
    chk("rst_rdy", rdy4, 1);
    chk4("rst", 0, 0, 0, 0);
    chk("rst_err", err4, 0);

    // Basic window of 4
    v4 = 1;
    put(2, 2, 0, 0, 1);     tick();
    put(22, 444, 1, 0, 0);  tick();
    put(444, 555, 1, 0, 0); tick();
    chk("w4_ov_early", ov4, 0);
    put(777, 111, 0, 1, 0); tick();
    chk("w4_ov", ov4, 1);
    chk("w4_rdy", rdy4, 0);
    chk4("w4", 2, 1, 1, 777);
    chk("w4_err", err4, 0);

    // Backpressure: in_valid held high with a tempting sample
    put(5000, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ov", ov4, 1);
      chk("bp_rdy", rdy4, 0);
      chk4("bp", 2, 1, 1, 777);
    end
    r4 = 1; tick(); r4 = 0; v4 = 0;
    chk("hs_ov", ov4, 0);
    chk("hs_rdy", rdy4, 1);
    chk4("hs", 0, 0, 0, 0);
    tick();
    chk4("hs_idle", 0, 0, 0, 0);

    // Reset mid-window
    v4 = 1;
    put(1, 50, 1, 0, 0); tick(); tick();
    v4 = 0;
    chk4("mid", 2, 0, 0, 50);
    rst = 1; #1;
    chk("rst_rdy_comb", rdy4, 0);
    tick();
    rst = 0; #1;
    chk("mrst_ov", ov4, 0);
    chk4("mrst", 0, 0, 0, 0);
    v4 = 1;
    put(3, 3, 0, 0, 1);    tick();
    put(10, 4, 0, 1, 0);   tick();
    put(6, 9, 1, 0, 0);    tick();
    chk("post_ov_early", ov4, 0);
    put(100, 20, 0, 1, 0); tick();
    v4 = 0;
    chk("post_ov", ov4, 1);
    chk4("post", 1, 2, 1, 100);
    handshake4();

    // Non-one-hot flags: Lesser and Greater both set
    v4 = 1;
    put(5, 9, 1, 1, 0);  tick();
    put(1, 1, 0, 0, 1);  tick();
    put(2, 3, 1, 0, 0);  tick();
    put(4, 2, 0, 1, 0);  tick();
    v4 = 0;
    chk("oh_ov", ov4, 1);
    chk4("oh", 2, 1, 1, 9);
    chk("oh_err", err4, exp_err);
    handshake4();
    chk("oh_err_clr", err4, 0);

    // Bubbles on WINDOW=3; junk samples during idle cycles must not count
    v3 = 1; put(7, 7, 0, 0, 1);       tick();
    chk("bub_ov1", ov3, 0);
    v3 = 0; put(1000, 0, 0, 1, 0);    tick();
    chk("bub_ov2", ov3, 0);
    v3 = 0; put(1000, 0, 0, 1, 0);    tick();
    chk("bub_ov3", ov3, 0);
    v3 = 1; put(1, 2, 1, 0, 0);       tick();
    chk("bub_ov4", ov3, 0);
    v3 = 0; put(2000, 0, 0, 1, 0);    tick();
    chk("bub_ov5", ov3, 0);
    v3 = 1; put(9, 3, 0, 1, 0);       tick();
    v3 = 0;
    chk("bub_ov6", ov3, 1);
    chk("bub_lt", lt3, 1);
    chk("bub_gt", gt3, 1);
    chk("bub_eq", eq3, 1);
    chk("bub_max", mx3, 9);

    // Saturation with CNT_W=2, WINDOW=6
    vs = 1; put(8888, 8888, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_ov_early", ovs, 0);
    tick();
    vs = 0;
    chk("sat_ov", ovs, 1);
    chk("sat_eq", eqs, 3);
    chk("sat_lt", lts, 0);
    chk("sat_gt", gts, 0);
    chk("sat_max", mxs, 8888);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cmp_window_stats.md
Name: cmp_window_stats

Overview:
- Downstream consumer of the N-bit comparator's outputs: a, b, Lesser, Greater, Equal.
- Accumulates results over a fixed window of WINDOW accepted samples: per-outcome counts and the running maximum of the larger operand.
- Presents a registered summary on a valid/ready output handshake, then clears and starts the next window.
- Used as a self-checking stats stage behind the comparator in regression and on-board monitors.

Parameters:
- WIDTH, 32: operand width; must match the upstream comparator.
- WINDOW, 8: accepted samples per report window; legal range 1 to 2^16-1.
- CNT_W, 16: width of each outcome counter; counters saturate.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample.
- a  in  WIDTH  operand A as fed to the comparator.
- b  in  WIDTH  operand B as fed to the comparator.
- Lesser  in  1  comparator flag, a<b.
- Greater  in  1  comparator flag, a>b.
- Equal  in  1  comparator flag, a==b.
- out_valid  out  1  window summary valid.
- out_ready  in  1  downstream accepts the summary.
- lt_cnt  out  CNT_W  count of samples classified Lesser.
- gt_cnt  out  CNT_W  count of samples classified Greater.
- eq_cnt  out  CNT_W  count of samples classified Equal.
- max_val  out  WIDTH  unsigned maximum of the winning operand over the window.
- err  out  1  flag-consistency error; see Optional Feature.

Behaviour:
- Reset (rst=1 at a clock edge): state=ACCUM; lt_cnt, gt_cnt, eq_cnt = 0; max_val = 0; err = 0; out_valid = 0; sample index = 0.
- in_ready is combinational: 1 only when state==ACCUM and rst==0.
- Reset mid-window or mid-report discards all partial results; the next sample is index 0.
- States:
  - ACCUM: accept when in_valid && in_ready. Cycles with in_valid=0 change nothing.
  - REPORT: out_valid=1, in_ready=0, all outputs held stable until out_valid && out_ready.
- Classification priority when more than one flag is set: Equal > Lesser > Greater.
  - All flags 0: sample counts toward WINDOW but increments no counter.
- Counters saturate at 2^CNT_W-1; no wrap.
- Winner per sample: b if the sample is classified Lesser, else a.
  - max_val <= winner if winner > max_val (unsigned compare inside this block).
- Sample index increments per accepted sample.
  - On acceptance of index WINDOW-1, next state is REPORT.
  - out_valid rises the cycle after the last accept; outputs include that sample (latency 1).
- REPORT handshake: on the edge with out_valid && out_ready:
  - counters, max_val, err and index clear;
  - state returns to ACCUM, out_valid=0, in_ready=1 on the following cycle.
  - No sample is accepted in the handshake cycle.
- During ACCUM, lt_cnt/gt_cnt/eq_cnt/max_val show running values but are qualified only by out_valid.
- WINDOW=1: every accepted sample produces a report; maximum throughput is one sample per 2 cycles.

Optional Feature:
- Macro: CMP_ONEHOT_CHECK_EN.
- Defined: on each accepted sample, if {Lesser,Greater,Equal} is not exactly one-hot, err is set.
  - err is sticky for the window, reported with the summary, and cleared at the handshake.
  - The sample is still classified by the priority rule above.
- Undefined: no check logic is built and err is tied to 0; all other behaviour is identical.

Test Plan:
- WINDOW=4, samples (2,2,E), (22,444,L), (444,555,L), (777,111,G) with in_valid held high -> out_valid=1 one cycle after the 4th accept; lt_cnt=2, gt_cnt=1, eq_cnt=1, max_val=777.
- Backpressure: out_ready=0 for 5 cycles during REPORT -> out_valid stays 1, in_ready=0, outputs constant. Raise out_ready -> next cycle out_valid=0, in_ready=1, all counts 0, max_val=0.
- Bubbles: WINDOW=3, in_valid toggled 1,0,0,1,0,1 -> exactly 3 samples counted; report one cycle after the 6th input cycle.
- Saturation: CNT_W=2, WINDOW=6, all samples (8888,8888,E) -> eq_cnt=3 (saturated), lt_cnt=gt_cnt=0, max_val=8888.
- Reset mid-window: 2 samples accepted, then rst=1 for one cycle -> all outputs 0, out_valid=0. The next 4-sample window reports only its own counts.
- Flags Lesser=1, Greater=1 on a=5, b=9 -> lt_cnt increments and max_val=9. err=1 in the report with CMP_ONEHOT_CHECK_EN defined; err=0 without it.
